// File: rtl/i2c_slave_mem_if.sv
// Sideband of the I2C memory target: the SCL input plus the status and
// memory-access outputs. SDA is open-drain and stays a plain inout port.
interface i2c_slave_mem_if;
  logic       scl;
  logic       busy;
  logic       done;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;

  modport master (output scl, input busy, done, mem_we, mem_addr, mem_wdata);
  modport slave  (input scl, output busy, done, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/i2c_slave_mem.sv
// I2C target with a 256-byte register memory: the first written byte sets the
// pointer, later bytes are written or read with auto-increment. Bus is oversampled.
module i2c_slave_mem #(
  parameter logic [6:0] slave_addr = 7'h50
) (
  input  logic           clk,
  input  logic           rst,
  inout  wire            sda,
  i2c_slave_mem_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  bit_cnt_reg, bit_cnt_next;
  logic [7:0]  shift_reg, shift_next;
  logic [7:0]  ptr_reg, ptr_next;
  logic        rw_reg, rw_next;
  logic        sda_oe_reg, sda_oe_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        mem_we_reg, mem_we_next;
  logic [7:0]  mem_addr_reg, mem_addr_next;
  logic [7:0]  mem_wdata_reg, mem_wdata_next;
  logic        wr_en;

  logic        scl_s1_reg, scl_s2_reg, scl_s3_reg;
  logic        sda_s1_reg, sda_s2_reg, sda_s3_reg;
  logic        scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]  byte_in;

  logic [7:0]  mem [256];
  logic [7:0]  rd_data_reg;

  // Open-drain: only ever pull low
  assign sda = sda_oe_reg ? 1'b0 : 1'bz;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s1_reg <= 1'b1;
      scl_s2_reg <= 1'b1;
      scl_s3_reg <= 1'b1;
      sda_s1_reg <= 1'b1;
      sda_s2_reg <= 1'b1;
      sda_s3_reg <= 1'b1;
    end else begin
      scl_s1_reg <= bus.scl;
      scl_s2_reg <= scl_s1_reg;
      scl_s3_reg <= scl_s2_reg;
      sda_s1_reg <= sda;
      sda_s2_reg <= sda_s1_reg;
      sda_s3_reg <= sda_s2_reg;
    end
  end

  assign scl_rise  = scl_s2_reg & ~scl_s3_reg;
  assign scl_fall  = ~scl_s2_reg & scl_s3_reg;
  assign start_det = scl_s2_reg & scl_s3_reg & sda_s3_reg & ~sda_s2_reg;
  assign stop_det  = scl_s2_reg & scl_s3_reg & ~sda_s3_reg & sda_s2_reg;
  assign byte_in   = {shift_reg[6:0], sda_s2_reg};

  // Memory has no reset; read port always tracks the current pointer
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[ptr_reg] <= byte_in;
    end
    rd_data_reg <= mem[ptr_reg];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= 4'd0;
      shift_reg     <= 8'd0;
      ptr_reg       <= 8'd0;
      rw_reg        <= 1'b0;
      sda_oe_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= 8'd0;
      mem_wdata_reg <= 8'd0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      ptr_reg       <= ptr_next;
      rw_reg        <= rw_next;
      sda_oe_reg    <= sda_oe_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
    end
  end

  // Ack states: bit_cnt 8 = waiting for the fall after bit 8, 9 = inside the ninth bit
  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    ptr_next       = ptr_reg;
    rw_next        = rw_reg;
    sda_oe_next    = sda_oe_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    mem_we_next    = 1'b0;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    wr_en          = 1'b0;

    if (start_det) begin
      state_next   = ADDR;
      bit_cnt_next = 4'd0;
      sda_oe_next  = 1'b0;
    end else if (stop_det) begin
      state_next  = IDLE;
      sda_oe_next = 1'b0;
      done_next   = busy_reg;
      busy_next   = 1'b0;
    end else if (scl_rise) begin
      case (state_reg)
        ADDR, PTR, WDATA: begin
          shift_next   = byte_in;
          bit_cnt_next = bit_cnt_reg + 4'd1;
          if (bit_cnt_reg == 4'd7) begin
            if (state_reg == ADDR) begin
              if (byte_in[7:1] == slave_addr) begin
                state_next = ADDR_ACK;
                rw_next    = byte_in[0];
              end else begin
                state_next = IDLE;
                busy_next  = 1'b0;
              end
            end else if (state_reg == PTR) begin
              ptr_next   = byte_in;
              state_next = PTR_ACK;
            end else begin
              wr_en          = 1'b1;
              mem_we_next    = 1'b1;
              mem_addr_next  = ptr_reg;
              mem_wdata_next = byte_in;
              ptr_next       = ptr_reg + 8'd1;
              state_next     = WDATA_ACK;
            end
          end
        end
        RDATA: begin
          bit_cnt_next = bit_cnt_reg + 4'd1;
          if (bit_cnt_reg == 4'd7) begin
            ptr_next   = ptr_reg + 8'd1;
            state_next = RDATA_ACK;
          end
        end
        RDATA_ACK: begin
          if (bit_cnt_reg == 4'd9 && sda_s2_reg) begin
            state_next = IDLE;
            busy_next  = 1'b0;
          end
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state_reg)
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (bit_cnt_reg == 4'd8) begin
            sda_oe_next  = 1'b1;
            bit_cnt_next = 4'd9;
            if (state_reg == ADDR_ACK) begin
              busy_next = 1'b1;
            end
          end else begin
            bit_cnt_next = 4'd0;
            sda_oe_next  = 1'b0;
            if (state_reg == ADDR_ACK && rw_reg) begin
              shift_next    = rd_data_reg;
              sda_oe_next   = ~rd_data_reg[7];
              mem_addr_next = ptr_reg;
              state_next    = RDATA;
            end else if (state_reg == ADDR_ACK) begin
              state_next = PTR;
            end else begin
              state_next = WDATA;
            end
          end
        end
        RDATA: begin
          if (bit_cnt_reg != 4'd0) begin
            shift_next  = {shift_reg[6:0], 1'b0};
            sda_oe_next = ~shift_reg[6];
          end
        end
        RDATA_ACK: begin
          if (bit_cnt_reg == 4'd8) begin
            sda_oe_next  = 1'b0;
            bit_cnt_next = 4'd9;
          end else begin
            shift_next    = rd_data_reg;
            sda_oe_next   = ~rd_data_reg[7];
            mem_addr_next = ptr_reg;
            bit_cnt_next  = 4'd0;
            state_next    = RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_i2c_slave_mem.sv
// Directed bench for i2c_slave_mem: a bit-banged master with a scoreboard of
// expected memory writes and read-back bytes.
module tb_i2c_slave_mem;
  localparam int Q = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_sda_low = 1'b0;
  wire  sda;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int we_cnt = 0;
  logic [15:0] we_q[$];
  logic [7:0]  rd_q[$];

  i2c_slave_mem_if bus_if();

  i2c_slave_mem #(.slave_addr(7'h50)) dut (
    .clk(clk),
    .rst(rst),
    .sda(sda),
    .bus(bus_if)
  );

  pullup (sda);
  assign sda = m_sda_low ? 1'b0 : 1'bz;

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write scoreboard and done-cycle counter
  always @(negedge clk) begin
    if (bus_if.done === 1'b1) done_cnt++;
    if (bus_if.mem_we === 1'b1) begin
      we_cnt++;
      check("we_expected", 16'(we_q.size() != 0), 16'd1);
      if (we_q.size() != 0) begin
        logic [15:0] e;
        e = we_q.pop_front();
        check("we_addr_data", {bus_if.mem_addr, bus_if.mem_wdata}, e);
      end
    end
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL timeout: observed no finish expected finish within 80000 cycles");
    $fatal(1, "timeout");
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda_low = 1'b0; wait_q();
    bus_if.scl = 1'b1; wait_q();
    m_sda_low = 1'b1; wait_q();
    bus_if.scl = 1'b0; wait_q();
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1; wait_q();
    bus_if.scl = 1'b1; wait_q();
    m_sda_low = 1'b0; wait_q();
  endtask

  task automatic clock_bit(input logic b, output logic s);
    m_sda_low = ~b; wait_q();
    bus_if.scl = 1'b1; wait_q();
    s = sda; wait_q();
    bus_if.scl = 1'b0; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(1'b1, d[i]);
    clock_bit(nack, s);
  endtask

  task automatic tx(input string tag, input logic [7:0] b, input logic exp_ack);
    logic ack;
    send_byte(b, ack);
    check(tag, 16'(ack), 16'(exp_ack));
  endtask

  task automatic wr_data(input logic [7:0] a, input logic [7:0] d);
    we_q.push_back({a, d});
    tx("wdata_ack", d, 1'b0);
  endtask

  task automatic rd_data(input logic [7:0] exp, input logic nack);
    logic [7:0] d;
    rd_q.push_back(exp);
    recv_byte(nack, d);
    check("rdata", 16'(d), 16'(rd_q.pop_front()));
  endtask

  task automatic set_ptr(input logic [7:0] p);
    bus_start();
    tx("addr_w_ack", 8'hA0, 1'b0);
    tx("ptr_ack", p, 1'b0);
  endtask

  initial begin
    logic s;
    bus_if.scl = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_busy", 16'(bus_if.busy), 16'd0);
    check("rst_done", 16'(bus_if.done), 16'd0);
    check("rst_we", 16'(bus_if.mem_we), 16'd0);
    check("rst_addr", 16'(bus_if.mem_addr), 16'd0);
    check("rst_wdata", 16'(bus_if.mem_wdata), 16'd0);
    check("rst_sda", 16'(sda), 16'd1);
    rst = 1'b0;
    wait_q();

    // Plain write of two bytes
    bus_start();
    tx("addr_w_ack", 8'hA0, 1'b0);
    check("busy_after_ack", 16'(bus_if.busy), 16'd1);
    tx("ptr_ack", 8'h10, 1'b0);
    wr_data(8'h10, 8'hA5);
    wr_data(8'h11, 8'h3C);
    bus_stop(); wait_q();
    exp_done++;
    check("write_done", 16'(done_cnt), 16'(exp_done));
    check("write_we_cnt", 16'(we_cnt), 16'd2);

    // Read back with repeated START, ACK then NACK
    set_ptr(8'h10);
    bus_start();
    tx("addr_r_ack", 8'hA1, 1'b0);
    rd_data(8'hA5, 1'b0);
    rd_data(8'h3C, 1'b1);
    check("sda_after_nack", 16'(sda), 16'd1);
    check("busy_after_nack", 16'(bus_if.busy), 16'd0);
    bus_stop(); wait_q();
    check("read_no_done", 16'(done_cnt), 16'(exp_done));

    // Pointer wrap on write and read
    set_ptr(8'hFF);
    wr_data(8'hFF, 8'h11);
    wr_data(8'h00, 8'h22);
    bus_stop(); wait_q();
    exp_done++;
    check("wrap_done", 16'(done_cnt), 16'(exp_done));
    set_ptr(8'hFF);
    bus_start();
    tx("addr_r_ack", 8'hA1, 1'b0);
    rd_data(8'h11, 1'b0);
    rd_data(8'h22, 1'b1);
    bus_stop(); wait_q();

    // Address mismatch: no ACK, following byte ignored
    bus_start();
    tx("mismatch_nack", 8'hA2, 1'b1);
    check("mismatch_busy", 16'(bus_if.busy), 16'd0);
    tx("ignored_nack", 8'h00, 1'b1);
    bus_stop(); wait_q();
    check("mismatch_no_done", 16'(done_cnt), 16'(exp_done));

    // STOP after 5 bits of a data byte
    set_ptr(8'h20);
    for (int i = 0; i < 5; i++) clock_bit(i[0], s);
    bus_stop(); wait_q();
    exp_done++;
    check("abort_done", 16'(done_cnt), 16'(exp_done));
    check("abort_busy", 16'(bus_if.busy), 16'd0);

    // Reset while the target drives a 0 bit (MSB of 0x3C)
    set_ptr(8'h11);
    bus_start();
    tx("addr_r_ack", 8'hA1, 1'b0);
    check("rd_bit_driven", 16'(sda), 16'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_sda", 16'(sda), 16'd1);
    check("rst_mid_busy", 16'(bus_if.busy), 16'd0);
    check("rst_mid_addr", 16'(bus_if.mem_addr), 16'd0);
    check("rst_mid_wdata", 16'(bus_if.mem_wdata), 16'd0);
    rst = 1'b0;
    wait_q();
    bus_stop(); wait_q();
    check("rst_mid_no_done", 16'(done_cnt), 16'(exp_done));

    // Normal operation after reset
    set_ptr(8'h30);
    wr_data(8'h30, 8'h77);
    bus_stop(); wait_q();
    exp_done++;
    set_ptr(8'h30);
    bus_start();
    tx("addr_r_ack", 8'hA1, 1'b0);
    rd_data(8'h77, 1'b1);
    bus_stop(); wait_q();
    check("final_done", 16'(done_cnt), 16'(exp_done));
    check("we_q_drained", 16'(we_q.size()), 16'd0);
    check("final_we_cnt", 16'(we_cnt), 16'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_slave_mem.md
# i2c_slave_mem

I2C target device with a 256-byte register memory: the endpoint that the I2C master drives over the shared `sda`/`scl` bus in the memory subsystem. It decodes START/STOP, matches its 7-bit address, and takes the first written byte as the memory pointer. Later bytes are written to memory, or read back from it, with pointer auto-increment. It runs from the same system clock as the master and samples the bus by oversampling; there is no clock stretching.

## Interface
- `slaveAddr`, default 7'h50: 7-bit device address this block answers to.
- `clk`  in  1  system clock (50 MHz); the only clock.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `scl`  in  1  I2C clock from the master; sampled only, never driven.
- `sda`  inout  1  I2C data; open-drain: driven 0 or released to `'z'`, never driven 1.
- `busy`  out  1  high from the address ACK until the transaction ends.
- `done`  out  1  one-cycle pulse on STOP ending an addressed transaction.
- `memWe`  out  1  one-cycle pulse when a data byte is written to memory.
- `memAddr`  out  8  pointer value used for the current/last memory access.
- `memWdata`  out  8  byte written on the last `memWe`.

## Operation
- Input conditioning: `scl` and `sda` each pass through a 2-flop synchronizer, then a third register for edge detection.
  - Rise/fall are decided on the synchronized values only.
- Bus conditions:
  - START: `sda` falls while `scl` is high.
  - STOP: `sda` rises while `scl` is high.
  - Both are decoded in every state.
- Bit rules:
  - Data bits are sampled on the detected `scl` rise.
  - `sda` drive changes only on the detected `scl` fall.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- IDLE: `sda` released; waits for START.
- START (any state, including a repeated START): go to ADDR, clear the bit counter. The pointer is kept.
- ADDR: shift 8 bits MSB-first (7-bit address, then R/W).
  - Address ≠ `slaveAddr`: go to IDLE with no ACK; ignore the bus until the next START.
  - Address match: go to ADDR_ACK and pull `sda` low for the ninth bit.
- ADDR_ACK (released at the next `scl` fall):
  - W: go to PTR.
  - R: load shifter with mem[ptr], drive its MSB, go to RDATA.
- PTR: 8 bits go to the pointer; ACK in PTR_ACK, then go to WDATA.
- WDATA: after 8 bits, write mem[ptr], pulse `memWe`, increment ptr; ACK in WDATA_ACK, then go back to WDATA.
- RDATA: shift out 8 bits, then release `sda`; ptr increments after the 8th bit; go to RDATA_ACK.
- RDATA_ACK: sample the master's bit on `scl` rise.
  - 0 (ACK): load mem[ptr] at the `scl` fall and go to RDATA.
  - 1 (NACK): release `sda`, go to IDLE.
- STOP (any state): release `sda`, go to IDLE. Pulse `done` if `busy` was high.
- Pointer: 8-bit, wraps 0xFF→0x00, no error.
- Partial byte at STOP/START: discarded, no memory write.
- Memory is not cleared by `rst`; its contents are undefined after power-up.

## Timing
- Reset values: `busy`=0, `done`=0, `memWe`=0, `memAddr`=0, `memWdata`=0, `sda` released, state IDLE, ptr 0, synchronizer flops 1.
- Reset mid-transaction: `sda` is released in the cycle after `rst` is sampled high. The aborted transaction produces no `memWe` and no `done`.
- Detection latency: a pin change is acted on 3 `clk` after it occurs.
- `sda` drive latency: updates ≤1 `clk` after the detected `scl` fall, so ≤4 `clk` after the pin. This must be less than a quarter I2C period (125 `clk` at 100 kHz).
- `memWe` goes high in the cycle after the detected 8th-bit `scl` rise; `memAddr` and `memWdata` are valid in that same cycle.
- `done`: a single cycle, the cycle after STOP is detected.
- `busy` rises with the ADDR_ACK drive. It falls with `done`, on NACK-to-IDLE, or on a repeated START to a mismatched address.
- START and STOP detected in the same cycle cannot occur. If an `scl` edge and a START coincide, START wins.

## Test plan
- Write: START, 0xA0 (0x50/W), ptr 0x10, data 0xA5, 0x3C, STOP.
  - ACK on all four bytes.
  - mem[0x10]=0xA5, mem[0x11]=0x3C.
  - Two `memWe` pulses with `memAddr` 0x10, 0x11.
  - One `done` pulse.
- Read with repeated START: write ptr 0x10, Sr, 0xA1, master ACKs byte 1 and NACKs byte 2, STOP.
  - Returned bytes are 0xA5, 0x3C; `sda` released after the NACK.
- Wrap: ptr 0xFF, write 0x11, 0x22.
  - mem[0xFF]=0x11, mem[0x00]=0x22.
- Address mismatch: START, 0xA2 (0x51).
  - `sda` stays 'z' during the ninth bit; `busy`=0; no writes; following bytes are ignored until the next START.
- Abort: STOP after 5 bits of a data byte.
  - No `memWe`; `done` pulses; state IDLE.
- Reset mid-read: assert `rst` while driving a 0 bit.
  - `sda` released the next cycle; all outputs at reset values; the next transaction works normally.
